// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller for a word-addressed, byte-enabled, single-port data memory.
// Ports: req valid/ready handshake in, resp valid/ready handshake out, registered memory port.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              in_req_valid,
    output logic              out_req_ready,
    input  logic              in_req_store,
    input  logic [2:0]        in_req_funct3,
    input  logic [31:0]       in_req_addr,
    input  logic [31:0]       in_req_wdata,
    output logic              out_resp_valid,
    input  logic              in_resp_ready,
    output logic [31:0]       out_resp_rdata,
    output logic              out_resp_misaligned,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic              out_mem_rw_mode,
    output logic [31:0]       out_mem_write_data,
    output logic [3:0]        out_mem_byte_en,
    input  logic [31:0]       in_mem_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    logic        req_store;
    logic [2:0]  req_f3;
    logic [1:0]  req_off;
    logic        illegal;
    logic [3:0]  be_next;
    logic [31:0] wd_next;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;

    // Address bits above the memory range wrap and are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^in_req_addr[31:ADDR_W+2];

    assign out_req_ready = (state == IDLE);

    // Request decode: legality, byte enables and lane-replicated store data.
    always_comb begin
        illegal = 1'b1;
        be_next = 4'b0000;
        wd_next = in_req_wdata;
        case (in_req_funct3)
            3'b000: begin
                illegal = 1'b0;
                be_next = 4'b0001 << in_req_addr[1:0];
                wd_next = {4{in_req_wdata[7:0]}};
            end
            3'b001: begin
                illegal = in_req_addr[0];
                be_next = in_req_addr[1] ? 4'b1100 : 4'b0011;
                wd_next = {2{in_req_wdata[15:0]}};
            end
            3'b010: begin
                illegal = |in_req_addr[1:0];
                be_next = 4'b1111;
            end
            3'b100, 3'b101: illegal = in_req_store;
            default: illegal = 1'b1;
        endcase
    end

    // Load lane selection and extension from the registered memory output.
    always_comb begin
        lane_b    = in_mem_data[{req_off, 3'b000} +: 8];
        lane_h    = in_mem_data[{req_off[1], 4'b0000} +: 16];
        load_data = in_mem_data;
        case (req_f3)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_data = {24'd0, lane_b};
            3'b101:  load_data = {16'd0, lane_h};
            default: load_data = in_mem_data;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state               <= IDLE;
            req_store           <= 1'b0;
            req_f3              <= 3'b000;
            req_off             <= 2'b00;
            out_resp_valid      <= 1'b0;
            out_resp_rdata      <= 32'd0;
            out_resp_misaligned <= 1'b0;
            out_mem_addr        <= '0;
            out_mem_rw_mode     <= 1'b0;
            out_mem_write_data  <= 32'd0;
            out_mem_byte_en     <= 4'b0000;
        end else begin
            // Write strobes live for the single ISSUE cycle only.
            out_mem_rw_mode <= 1'b0;
            out_mem_byte_en <= 4'b0000;
            case (state)
                IDLE: begin
                    if (in_req_valid) begin
                        req_store <= in_req_store;
                        req_f3    <= in_req_funct3;
                        req_off   <= in_req_addr[1:0];
                        if (illegal) begin
                            out_resp_valid      <= 1'b1;
                            out_resp_misaligned <= 1'b1;
                            out_resp_rdata      <= 32'd0;
                            state               <= RESP;
                        end else begin
                            out_mem_addr <= in_req_addr[ADDR_W+1:2];
                            if (in_req_store) begin
                                out_mem_rw_mode    <= 1'b1;
                                out_mem_byte_en    <= be_next;
                                out_mem_write_data <= wd_next;
                            end
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (req_store) begin
                        out_resp_valid <= 1'b1;
                        out_resp_rdata <= 32'd0;
                        state          <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    out_resp_rdata <= load_data;
                    out_resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (in_resp_ready) begin
                        out_resp_valid      <= 1'b0;
                        out_resp_misaligned <= 1'b0;
                        state               <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-enabled registered-read memory model.
// Ports: drives all request/response inputs, models the data memory on the mem port.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_f3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_mis;
    logic [9:0]  mem_addr;
    logic        mem_rw;
    logic [31:0] mem_wd;
    logic [3:0]  mem_be;
    logic [31:0] mem_q = 32'd0;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    logic        rw_seen;
    logic [3:0]  be_seen;
    logic [31:0] wd_seen;
    logic [9:0]  ma_seen;

    lsu_mem_ctrl #(.ADDR_W(10)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .in_req_valid        (req_valid),
        .out_req_ready       (req_ready),
        .in_req_store        (req_store),
        .in_req_funct3       (req_f3),
        .in_req_addr         (req_addr),
        .in_req_wdata        (req_wdata),
        .out_resp_valid      (resp_valid),
        .in_resp_ready       (resp_ready),
        .out_resp_rdata      (resp_rdata),
        .out_resp_misaligned (resp_mis),
        .out_mem_addr        (mem_addr),
        .out_mem_rw_mode     (mem_rw),
        .out_mem_write_data  (mem_wd),
        .out_mem_byte_en     (mem_be),
        .in_mem_data         (mem_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_q <= mem[mem_addr];
        if (mem_rw)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wd[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_store = st;
        req_f3    = f3;
        req_addr  = a;
        req_wdata = wd;
    endtask

    // Starts one cycle after the accepting edge; lat counts edges from acceptance.
    task automatic wait_resp(output int lat);
        lat     = 1;
        rw_seen = 1'b0;
        be_seen = 4'b0000;
        wd_seen = 32'd0;
        ma_seen = mem_addr;
        while (!resp_valid && lat < 8) begin
            if (mem_rw) begin
                rw_seen = 1'b1;
                wd_seen = mem_wd;
            end
            be_seen = be_seen | mem_be;
            @(posedge clk);
            #1;
            lat++;
        end
        be_seen = be_seen | mem_be;
        if (mem_rw) rw_seen = 1'b1;
    endtask

    task automatic finish_resp(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, ".done"}, {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int elat, input logic [31:0] erd, input logic emis,
                       input logic [3:0] ebe, input logic [31:0] ewd);
        int lat;
        drive(st, f3, a, wd);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_resp(lat);
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".rdata"}, resp_rdata, erd);
        chk({tag, ".mis"}, {31'd0, resp_mis}, {31'd0, emis});
        chk({tag, ".be"}, {28'd0, be_seen}, {28'd0, ebe});
        chk({tag, ".rw"}, {31'd0, rw_seen}, {31'd0, (ebe != 4'b0000)});
        if (ebe != 4'b0000) begin
            chk({tag, ".wd"}, wd_seen, ewd);
            chk({tag, ".maddr"}, {22'd0, ma_seen}, {22'd0, a[11:2]});
        end
        finish_resp(tag);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[8] = 32'h1234_5678;

        #2;
        chk("rst.ready_in", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("rst.valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.mis", {31'd0, resp_mis}, 32'd0);
        chk("rst.maddr", {22'd0, mem_addr}, 32'd0);
        chk("rst.rw", {31'd0, mem_rw}, 32'd0);
        chk("rst.wd", mem_wd, 32'd0);
        chk("rst.be", {28'd0, mem_be}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.ready_after", {31'd0, req_ready}, 32'd1);

        txn("sw10", 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 2, 0, 0, 4'b1111, 32'hDEAD_BEEF);
        txn("sb13", 1, 3'b000, 32'h13, 32'h0000_00AA, 2, 0, 0, 4'b1000, 32'hAAAA_AAAA);
        txn("lb13", 0, 3'b000, 32'h13, 0, 3, 32'hFFFF_FFAA, 0, 4'b0000, 0);
        txn("lbu13", 0, 3'b100, 32'h13, 0, 3, 32'h0000_00AA, 0, 4'b0000, 0);
        txn("lw10", 0, 3'b010, 32'h10, 0, 3, 32'hAAAD_BEEF, 0, 4'b0000, 0);
        txn("lb10", 0, 3'b000, 32'h10, 0, 3, 32'hFFFF_FFEF, 0, 4'b0000, 0);
        txn("lhu12", 0, 3'b101, 32'h12, 0, 3, 32'h0000_AAAD, 0, 4'b0000, 0);
        txn("lbu11", 0, 3'b100, 32'h11, 0, 3, 32'h0000_00BE, 0, 4'b0000, 0);
        txn("sh22", 1, 3'b001, 32'h22, 32'h0000_8001, 2, 0, 0, 4'b1100, 32'h8001_8001);
        txn("lh22", 0, 3'b001, 32'h22, 0, 3, 32'hFFFF_8001, 0, 4'b0000, 0);
        txn("lhu22", 0, 3'b101, 32'h22, 0, 3, 32'h0000_8001, 0, 4'b0000, 0);
        txn("lw20", 0, 3'b010, 32'h20, 0, 3, 32'h8001_5678, 0, 4'b0000, 0);
        txn("lh20", 0, 3'b001, 32'h20, 0, 3, 32'h0000_5678, 0, 4'b0000, 0);
        txn("lwwrap", 0, 3'b010, 32'hFFFF_F010, 0, 3, 32'hAAAD_BEEF, 0, 4'b0000, 0);
        txn("sb00", 1, 3'b000, 32'h00, 32'h1234_5655, 2, 0, 0, 4'b0001, 32'h5555_5555);
        txn("lw00", 0, 3'b010, 32'h00, 0, 3, 32'h0000_0055, 0, 4'b0000, 0);

        txn("e_lw05", 0, 3'b010, 32'h05, 0, 1, 0, 1, 4'b0000, 0);
        txn("e_sh11", 1, 3'b001, 32'h11, 32'h1234, 1, 0, 1, 4'b0000, 0);
        txn("e_sbu", 1, 3'b100, 32'h00, 32'hAA, 1, 0, 1, 4'b0000, 0);
        txn("e_f011", 0, 3'b011, 32'h00, 0, 1, 0, 1, 4'b0000, 0);
        txn("e_f111", 0, 3'b111, 32'h10, 0, 1, 0, 1, 4'b0000, 0);
        txn("lw10b", 0, 3'b010, 32'h10, 0, 3, 32'hAAAD_BEEF, 0, 4'b0000, 0);

        drive(0, 3'b010, 32'h20, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_resp(lat);
        chk("bp.lat", lat, 3);
        drive(0, 3'b010, 32'h10, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp.valid", {31'd0, resp_valid}, 32'd1);
            chk("bp.rdata", resp_rdata, 32'h8001_5678);
            chk("bp.ready", {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("bp.done", {31'd0, resp_valid}, 32'd0);
        chk("bp.idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp.taken", {31'd0, req_ready}, 32'd0);
        wait_resp(lat);
        chk("bp2.lat", lat, 3);
        chk("bp2.rdata", resp_rdata, 32'hAAAD_BEEF);
        finish_resp("bp2");

        drive(1, 3'b010, 32'h20, 32'h1111_1111);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("ra.issue_rw", {31'd0, mem_rw}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra.rw", {31'd0, mem_rw}, 32'd0);
        chk("ra.be", {28'd0, mem_be}, 32'd0);
        chk("ra.maddr", {22'd0, mem_addr}, 32'd0);
        chk("ra.wd", mem_wd, 32'd0);
        chk("ra.ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("ra.noresp", {31'd0, resp_valid}, 32'd0);
        end
        txn("ra.lw20", 0, 3'b010, 32'h20, 0, 3, 32'h8001_5678, 0, 4'b0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller that initiates every access to the single-port data memory (word-addressed, byte-enabled, one-cycle registered read). It accepts RV32I load/store requests from the pipeline over a valid/ready handshake and performs alignment checking, byte-enable and store-lane generation, and load extraction with sign/zero extension. It returns one response per request over a second valid/ready handshake.

## Interface
- ADDR_W, 10, memory word-address width.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- in_req_valid  in  1  request present.
- out_req_ready  out  1  request accepted when high with in_req_valid.
- in_req_store  in  1  1 = store, 0 = load.
- in_req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are legal for loads only.
- in_req_addr  in  32  byte address.
- in_req_wdata  in  32  store data, right-aligned.
- out_resp_valid  out  1  response present.
- in_resp_ready  in  1  response consumed when high with out_resp_valid.
- out_resp_rdata  out  32  extended load data; 0 for stores and errors.
- out_resp_misaligned  out  1  request rejected (misaligned or illegal funct3).
- out_mem_addr  out  ADDR_W  memory word address.
- out_mem_rw_mode  out  1  0 = read, 1 = write.
- out_mem_write_data  out  32  lane-replicated store data.
- out_mem_byte_en  out  4  write byte enables.
- in_mem_data  in  32  memory read data; valid the cycle after a read address is presented.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. out_req_ready = (state == IDLE).
- IDLE, on handshake:
  - Capture the request.
  - Illegal (H with addr[0]=1; W with addr[1:0]≠0; funct3 011/110/111; BU/HU with store) -> RESP with misaligned=1. No memory access.
  - Otherwise -> ISSUE.
- ISSUE:
  - out_mem_addr = addr[ADDR_W+1:2]; upper address bits are ignored (wrap).
  - Store: rw=1. Byte_en = 1<<addr[1:0] (B), 0011/1100 by addr[1] (H), 1111 (W). Write_data = {4{wdata[7:0]}}, {2{wdata[15:0]}} or wdata. Next state RESP.
  - Load: rw=0, byte_en=0000. Next state WAIT.
- WAIT:
  - Select lane from in_mem_data: byte = bits [8*addr[1:0]+:8]; half = bits [16*addr[1]+:16].
  - Sign-extend for B/H, zero-extend for BU/HU.
  - Register the result into out_resp_rdata. Next state RESP.
- RESP: out_resp_valid=1. On in_resp_ready -> IDLE; clear out_resp_valid and out_resp_misaligned.
- Outside ISSUE: out_mem_rw_mode=0 and out_mem_byte_en=0000. out_mem_addr and out_mem_write_data hold their last values.
- All memory-side outputs are registered; none depend combinationally on in_req_*.

## Timing
- Reset values: state IDLE, out_resp_valid 0, out_resp_rdata 0, out_resp_misaligned 0, out_mem_addr 0, out_mem_rw_mode 0, out_mem_write_data 0, out_mem_byte_en 0. out_req_ready reads 1 while and after reset.
- Request accepted in cycle N:
  - Store: memory written at the end of N+1; out_resp_valid from N+2.
  - Load: read address at N+1, data at N+2, out_resp_valid from N+3.
  - Error: out_resp_valid from N+1.
- Response backpressure: out_resp_valid, out_resp_rdata and out_resp_misaligned stay stable until the handshake. No new request is accepted until the cycle after the response handshake.
- Load after store to the same word returns the newly written bytes.
- Reset mid-operation: rw_mode and byte_en drop to 0 immediately, the in-flight request is discarded, and no response is produced. A store aborted before its ISSUE edge does not write.

## Test plan
- SW 0xDEADBEEF @0x10 -> ISSUE cycle: mem_addr=4, rw=1, byte_en=1111, write_data=0xDEADBEEF; resp valid at N+2, rdata 0, misaligned 0.
- SB 0x000000AA @0x13 -> byte_en=1000, write_data=0xAAAAAAAA. Then LB @0x13 -> 0xFFFFFFAA at N+3; LBU @0x13 -> 0x000000AA.
- SH 0x00008001 @0x22 -> byte_en=1100. Then LH @0x22 -> 0xFFFF8001; LHU -> 0x00008001; LW @0x20 -> 0x8001xxxx with the low half unchanged.
- LW @0x05, SH @0x11, SB with funct3=100 -> misaligned=1 at N+1; rw and byte_en remain 0 throughout.
- Hold in_resp_ready low 5 cycles after an LW -> valid/rdata stable, out_req_ready=0, a pending in_req_valid is not accepted until after the handshake.
- Assert i_rst_n low mid-cycle during a store's ISSUE -> rw_mode=0 immediately, outputs at reset values. After release, LW to the same word returns the old value.
